// File: rtl/ff_fifo_burst_pkg.sv
// Shared helpers for the flip-flop FIFO: width math, output-mode constants
// and the parameter legality check used at elaboration.
package ff_fifo_pkg;

    localparam int unsigned FWFT_OFF = 0;
    localparam int unsigned FWFT_ON  = 1;

    // Ceiling log2, never below 1 so a derived bus is at least one bit wide
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (longint unsigned v = 1; v < longint'(value); v = v << 1) begin
            r++;
        end
        return (r == 0) ? 1 : r;
    endfunction

    function automatic bit params_ok(
        input int unsigned data_width,
        input int unsigned depth,
        input int unsigned fwft,
        input int unsigned aempty_lvl,
        input int unsigned afull_lvl
    );
        return (data_width >= 1) && (depth >= 2) &&
               (fwft == FWFT_OFF || fwft == FWFT_ON) &&
               (aempty_lvl < afull_lvl) && (afull_lvl <= depth);
    endfunction

endpackage

// File: rtl/ff_fifo_burst_wrap_ptr.sv
// Modulo-DEPTH pointer: increments on inc, wraps DEPTH-1 -> 0, clears on rst or clear.
module ff_fifo_wrap_ptr
    import ff_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned PTR_W = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == LAST) ? '0 : ptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/ff_fifo_burst.sv
// Circular-buffer FIFO in flip-flops with level, almost-flags, sticky
// overflow/underflow and either registered or first-word-fall-through output.
module ff_fifo_burst
    import ff_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned FWFT       = FWFT_OFF,
    parameter int unsigned AFULL_LVL  = FIFO_DEPTH - 2,
    parameter int unsigned AEMPTY_LVL = 2,
    localparam int unsigned LVL_W     = clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  write,
    input  logic                  read,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [LVL_W-1:0]      level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned PTR_W = clog2(FIFO_DEPTH);

    if (!params_ok(DATA_WIDTH, FIFO_DEPTH, FWFT, AEMPTY_LVL, AFULL_LVL)) begin : g_bad_params
        $error("ff_fifo_burst: illegal parameter combination");
    end

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  flush;
    logic [LVL_W-1:0]      level_nxt;

    // A write into a full FIFO is only taken when a read frees a slot the same cycle
    assign flush  = ~enable;
    assign rd_acc = read & ~empty & enable;
    assign wr_acc = write & enable & (~full | rd_acc);

    ff_fifo_wrap_ptr #(
        .DEPTH (FIFO_DEPTH)
    ) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .inc   (wr_acc),
        .ptr   (wr_ptr)
    );

    ff_fifo_wrap_ptr #(
        .DEPTH (FIFO_DEPTH)
    ) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .inc   (rd_acc),
        .ptr   (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_comb begin
        level_nxt = level;
        if (wr_acc && !rd_acc) begin
            level_nxt = level + LVL_W'(1);
        end else if (rd_acc && !wr_acc) begin
            level_nxt = level - LVL_W'(1);
        end
    end

    // Flags are registered from the next level so they track the level register exactly
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            level        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            level        <= level_nxt;
            empty        <= (level_nxt == '0);
            full         <= (level_nxt == LVL_W'(FIFO_DEPTH));
            almost_empty <= (level_nxt <= LVL_W'(AEMPTY_LVL));
            almost_full  <= (level_nxt >= LVL_W'(AFULL_LVL));
            if (write && !wr_acc) begin
                overflow <= 1'b1;
            end
            if (read && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    if (FWFT == FWFT_ON) begin : g_fwft
        assign data_out       = mem[rd_ptr];
        assign data_out_valid = ~empty;
    end else begin : g_reg
        // data_out holds across a flush; only rst returns it to zero
        always_ff @(posedge clk) begin
            if (rst) begin
                data_out       <= '0;
                data_out_valid <= 1'b0;
            end else begin
                data_out_valid <= rd_acc;
                if (rd_acc) begin
                    data_out <= mem[rd_ptr];
                end
            end
        end
    end

endmodule

// File: tb/tb_ff_fifo_burst.sv
// Bench for ff_fifo_burst: registered and FWFT instances share stimulus and
// are compared every cycle against a queue-based reference model.
module tb_ff_fifo_burst;

    localparam int unsigned DW     = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned AFULL  = 3;
    localparam int unsigned AEMPTY = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b1;
    logic [DW-1:0] data_in = '0;
    logic          write = 1'b0;
    logic          read = 1'b0;

    logic [DW-1:0] r_dout, f_dout;
    logic          r_dv, f_dv;
    logic          r_empty, f_empty, r_full, f_full;
    logic          r_ae, f_ae, r_af, f_af;
    logic [2:0]    r_level, f_level;
    logic          r_ovf, f_ovf, r_unf, f_unf;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    logic [DW-1:0] q[$];
    bit            m_ovf = 0;
    bit            m_unf = 0;
    bit            m_dv  = 0;
    logic [DW-1:0] m_dout = '0;

    always #5 clk = ~clk;

    ff_fifo_burst #(
        .DATA_WIDTH (DW), .FIFO_DEPTH (DEPTH), .FWFT (0),
        .AFULL_LVL (AFULL), .AEMPTY_LVL (AEMPTY)
    ) u_reg (
        .clk (clk), .rst (rst), .enable (enable), .data_in (data_in),
        .write (write), .read (read), .data_out (r_dout), .data_out_valid (r_dv),
        .empty (r_empty), .full (r_full), .almost_empty (r_ae), .almost_full (r_af),
        .level (r_level), .overflow (r_ovf), .underflow (r_unf)
    );

    ff_fifo_burst #(
        .DATA_WIDTH (DW), .FIFO_DEPTH (DEPTH), .FWFT (1),
        .AFULL_LVL (AFULL), .AEMPTY_LVL (AEMPTY)
    ) u_fwft (
        .clk (clk), .rst (rst), .enable (enable), .data_in (data_in),
        .write (write), .read (read), .data_out (f_dout), .data_out_valid (f_dv),
        .empty (f_empty), .full (f_full), .almost_empty (f_ae), .almost_full (f_af),
        .level (f_level), .overflow (f_ovf), .underflow (f_unf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: a plain queue with the acceptance rules applied to its size
    task automatic model(input bit w, input bit r, input bit en, input bit rs, input logic [DW-1:0] d);
        bit rd_ok, wr_ok;
        if (rs) begin
            q.delete(); m_ovf = 0; m_unf = 0; m_dv = 0; m_dout = '0;
        end else if (!en) begin
            q.delete(); m_ovf = 0; m_unf = 0; m_dv = 0;
        end else begin
            rd_ok = r && (q.size() != 0);
            wr_ok = w && ((q.size() < DEPTH) || rd_ok);
            if (r && q.size() == 0) m_unf = 1;
            if (w && !wr_ok) m_ovf = 1;
            m_dv = rd_ok;
            if (rd_ok) m_dout = q.pop_front();
            if (wr_ok) q.push_back(d);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("level",        32'(r_level), 32'(n));
        chk("empty",        32'(r_empty), 32'(n == 0));
        chk("full",         32'(r_full),  32'(n == DEPTH));
        chk("almost_empty", 32'(r_ae),    32'(n <= AEMPTY));
        chk("almost_full",  32'(r_af),    32'(n >= AFULL));
        chk("overflow",     32'(r_ovf),   32'(m_ovf));
        chk("underflow",    32'(r_unf),   32'(m_unf));
        chk("reg_valid",    32'(r_dv),    32'(m_dv));
        chk("reg_data",     32'(r_dout),  32'(m_dout));
        chk("fwft_level",   32'(f_level), 32'(n));
        chk("fwft_valid",   32'(f_dv),    32'(n != 0));
        chk("fwft_ovf_unf", 32'({f_ovf, f_unf}), 32'({m_ovf, m_unf}));
        if (n != 0) chk("fwft_data", 32'(f_dout), 32'(q[0]));
    endtask

    task automatic step(input bit w, input bit r, input bit en, input bit rs, input logic [DW-1:0] d);
        @(negedge clk);
        write = w; read = r; enable = en; rst = rs; data_in = d;
        @(posedge clk);
        model(w, r, en, rs, d);
        #1 check_all();
    endtask

    initial begin
        int wb, rb;
        // reset
        step(0, 0, 1, 1, 8'h00);
        step(0, 0, 1, 1, 8'h00);
        chk("reset_aempty", 32'(r_ae), 32'(1));
        // burst fill A0..A3
        for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 8'(8'hA0 + i));
        chk("burst_full", 32'(r_full), 32'(1));
        chk("burst_no_ovf", 32'(r_ovf), 32'(0));
        // full: write+read together six times to wrap both pointers
        for (int i = 0; i < 6; i++) step(1, 1, 1, 0, 8'(8'hB0 + i));
        chk("wrap_level", 32'(r_level), 32'(4));
        // full: write without read is rejected
        step(1, 0, 1, 0, 8'hCC);
        chk("ovf_set", 32'(r_ovf), 32'(1));
        // drain, then one extra read underflows
        for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 8'h00);
        chk("unf_set", 32'(r_unf), 32'(1));
        step(0, 0, 1, 0, 8'h00);
        // write into empty with same-cycle read: read rejected, no bypass
        step(1, 1, 1, 0, 8'h5A);
        chk("fwft_5a", 32'(f_dout), 32'(8'h5A));
        step(0, 0, 1, 0, 8'h00);
        step(0, 1, 1, 0, 8'h00);
        chk("fwft_drained", 32'(f_empty), 32'(1));
        // flush via enable at level 3
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 8'(8'h70 + i));
        step(1, 1, 0, 0, 8'hEE);
        chk("flush_empty", 32'(r_empty), 32'(1));
        step(1, 0, 1, 0, 8'h11);
        step(0, 1, 1, 0, 8'h00);
        chk("flush_readback", 32'(r_dout), 32'(8'h11));
        // same with rst
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 8'(8'h80 + i));
        step(1, 1, 1, 1, 8'hEE);
        step(1, 0, 1, 0, 8'h11);
        step(0, 1, 1, 0, 8'h00);
        chk("rst_readback", 32'(r_dout), 32'(8'h11));
        // random phases alternating write-heavy and read-heavy
        for (int i = 0; i < 600; i++) begin
            wb = ((i / 40) % 2 == 0) ? 75 : 30;
            rb = ((i / 40) % 2 == 0) ? 30 : 75;
            step($urandom_range(0, 99) < wb, $urandom_range(0, 99) < rb,
                 $urandom_range(0, 29) != 0, $urandom_range(0, 79) == 0,
                 8'($urandom));
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
